// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state numbering common to transmitter and receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_CNT_W     = 8;

   // Same numbering as the receiver so both ends decode alike in waveforms.
   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      START   = 3'b001,
      DATA    = 3'b010,
      STOP    = 3'b011,
      CLEANUP = 3'b100
   } uart_state_t;

   // States during which a frame is on the line (start through stop inclusive).
   function automatic logic is_frame_state(input uart_state_t s);
      return (s == START) || (s == DATA) || (s == STOP);
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte push handshake plus serial/status outputs of the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: host may push only while o_Tx_Ready is high; otherwise the byte is dropped.
//   i_Tx_DV/i_Tx_Byte : host -> transmitter push
//   o_Tx_Ready        : transmitter FIFO not full
//   o_Tx_Serial/o_Tx_Active/o_Tx_Done : line and frame status
interface uart_tx_if;
   import uart_pkg::*;

   logic                      i_Tx_DV;
   logic [UART_DATA_BITS-1:0] i_Tx_Byte;
   logic                      o_Tx_Ready;
   logic                      o_Tx_Serial;
   logic                      o_Tx_Active;
   logic                      o_Tx_Done;

   modport master (
      output i_Tx_DV, i_Tx_Byte,
      input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
   );

   modport slave (
      input  i_Tx_DV, i_Tx_Byte,
      output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO feeding the transmitter; head is readable combinationally.
// Latency: a written byte is visible at the head the cycle after the write.
// Backpressure: writes while o_Full are ignored; reads while o_Empty are ignored.
//   i_Wr_En/i_Wr_Data/o_Full : tail side
//   i_Rd_En/o_Rd_Data/o_Empty: head side
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      i_Clock,
   input  logic                      i_Rst_n,
   input  logic                      i_Wr_En,
   input  logic [UART_DATA_BITS-1:0] i_Wr_Data,
   output logic                      o_Full,
   input  logic                      i_Rd_En,
   output logic [UART_DATA_BITS-1:0] o_Rd_Data,
   output logic                      o_Empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]               r_Wr_Ptr;
   logic [AW:0]               r_Rd_Ptr;
   logic [UART_DATA_BITS-1:0] r_Mem [DEPTH];
   logic                      w_Push;
   logic                      w_Pop;

   assign o_Empty   = (r_Wr_Ptr == r_Rd_Ptr);
   assign o_Full    = (r_Wr_Ptr[AW] != r_Rd_Ptr[AW]) &&
                      (r_Wr_Ptr[AW-1:0] == r_Rd_Ptr[AW-1:0]);
   assign o_Rd_Data = r_Mem[r_Rd_Ptr[AW-1:0]];

   assign w_Push = i_Wr_En && !o_Full;
   assign w_Pop  = i_Rd_En && !o_Empty;

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_Wr_Ptr <= '0;
         r_Rd_Ptr <= '0;
      end else begin
         if (w_Push) r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
         if (w_Pop)  r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      end
   end

   // Storage needs no reset: contents are only observed between valid pointers.
   always_ff @(posedge i_Clock) begin
      if (w_Push) r_Mem[r_Wr_Ptr[AW-1:0]] <= i_Wr_Data;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO.
// Latency: push into empty FIFO while idle -> start bit on the line one cycle later.
// Backpressure: o_Tx_Ready = FIFO not full; pushes while not ready are dropped.
//   i_Clock, i_Rst_n (synchronous, active-low)
//   bus : uart_tx_if.slave (push handshake, serial line, active/done status)
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic     i_Clock,
   input  logic     i_Rst_n,
   uart_tx_if.slave bus
);

   localparam logic [UART_CNT_W-1:0] CNT_LAST = UART_CNT_W'(CLKS_PER_BIT - 1);

   uart_state_t               r_State;
   uart_state_t               w_State_Next;
   logic [UART_CNT_W-1:0]     r_Clock_Count;
   logic [UART_CNT_W-1:0]     w_Clock_Count_Next;
   logic [2:0]                r_Bit_Index;
   logic [2:0]                w_Bit_Index_Next;
   logic [UART_DATA_BITS-1:0] r_Tx_Data;
   logic [UART_DATA_BITS-1:0] w_Tx_Data_Next;
   logic                      r_Tx_Serial;
   logic                      r_Tx_Active;
   logic                      r_Tx_Done;
   logic                      w_Serial_Next;
   logic                      w_Active_Next;
   logic                      w_Done_Next;
   logic                      w_Bit_End;

   logic                      w_Fifo_Full;
   logic                      w_Fifo_Empty;
   logic                      w_Fifo_Rd_En;
   logic [UART_DATA_BITS-1:0] w_Fifo_Rd_Data;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_Clock   (i_Clock),
      .i_Rst_n   (i_Rst_n),
      .i_Wr_En   (bus.i_Tx_DV),
      .i_Wr_Data (bus.i_Tx_Byte),
      .o_Full    (w_Fifo_Full),
      .i_Rd_En   (w_Fifo_Rd_En),
      .o_Rd_Data (w_Fifo_Rd_Data),
      .o_Empty   (w_Fifo_Empty)
   );

   assign w_Bit_End = (r_Clock_Count == CNT_LAST);

   always_comb begin
      w_State_Next       = r_State;
      w_Clock_Count_Next = r_Clock_Count;
      w_Bit_Index_Next   = r_Bit_Index;
      w_Tx_Data_Next     = r_Tx_Data;
      w_Fifo_Rd_En       = 1'b0;

      case (r_State)
         IDLE: begin
            if (!w_Fifo_Empty) begin
               w_Fifo_Rd_En       = 1'b1;
               w_Tx_Data_Next     = w_Fifo_Rd_Data;
               w_Clock_Count_Next = '0;
               w_Bit_Index_Next   = '0;
               w_State_Next       = START;
            end
         end
         START: begin
            if (w_Bit_End) begin
               w_Clock_Count_Next = '0;
               w_State_Next       = DATA;
            end else begin
               w_Clock_Count_Next = r_Clock_Count + UART_CNT_W'(1);
            end
         end
         DATA: begin
            if (w_Bit_End) begin
               w_Clock_Count_Next = '0;
               // 3-bit index wraps 7->0 on the last bit, leaving it cleared for the next frame.
               w_Bit_Index_Next   = r_Bit_Index + 3'd1;
               if (r_Bit_Index == 3'd7) w_State_Next = STOP;
            end else begin
               w_Clock_Count_Next = r_Clock_Count + UART_CNT_W'(1);
            end
         end
         STOP: begin
            if (w_Bit_End) begin
               w_Clock_Count_Next = '0;
               w_State_Next       = CLEANUP;
            end else begin
               w_Clock_Count_Next = r_Clock_Count + UART_CNT_W'(1);
            end
         end
         CLEANUP: w_State_Next = IDLE;
         default: w_State_Next = IDLE;
      endcase

      // Outputs are registered from the next state so the line level lines up
      // with the state register instead of trailing it by a cycle.
      w_Serial_Next = 1'b1;
      w_Active_Next = is_frame_state(w_State_Next);
      w_Done_Next   = (w_State_Next == CLEANUP);
      case (w_State_Next)
         START:   w_Serial_Next = 1'b0;
         DATA:    w_Serial_Next = w_Tx_Data_Next[w_Bit_Index_Next];
         default: w_Serial_Next = 1'b1;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         r_State       <= IDLE;
         r_Clock_Count <= '0;
         r_Bit_Index   <= '0;
         r_Tx_Data     <= '0;
         r_Tx_Serial   <= 1'b1;
         r_Tx_Active   <= 1'b0;
         r_Tx_Done     <= 1'b0;
      end else begin
         r_State       <= w_State_Next;
         r_Clock_Count <= w_Clock_Count_Next;
         r_Bit_Index   <= w_Bit_Index_Next;
         r_Tx_Data     <= w_Tx_Data_Next;
         r_Tx_Serial   <= w_Serial_Next;
         r_Tx_Active   <= w_Active_Next;
         r_Tx_Done     <= w_Done_Next;
      end
   end

   assign bus.o_Tx_Ready  = ~w_Fifo_Full;
   assign bus.o_Tx_Serial = r_Tx_Serial;
   assign bus.o_Tx_Active = r_Tx_Active;
   assign bus.o_Tx_Done   = r_Tx_Done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (4 and 256 clocks per bit) checked every
// cycle against a frame-level model, plus directed literal checks.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int DEPTH = 4;

   logic clk      = 1'b0;
   logic rst4_n   = 1'b0;
   logic rst256_n = 1'b0;
   int   tests    = 0;
   int   fails    = 0;
   int   cyc      = 0;
   bit   chk_en   = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   uart_tx_if if4 ();
   uart_tx_if if256 ();

   uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH)) dut4 (
      .i_Clock (clk),
      .i_Rst_n (rst4_n),
      .bus     (if4)
   );

   uart_tx #(.CLKS_PER_BIT(256), .FIFO_DEPTH(DEPTH)) dut256 (
      .i_Clock (clk),
      .i_Rst_n (rst256_n),
      .bus     (if256)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- frame-level reference model ----------------
   // Each instance: a byte queue of at most DEPTH entries, and the current
   // frame expressed as cycles elapsed since the pop (t). Frame: t in
   // [0,10*cpb) carries the ten bit slots, t==10*cpb is the done cycle, and
   // one idle cycle follows before the next pop.
   logic [7:0] m_q   [2][16];
   int         m_cnt [2];
   bit         m_busy[2];
   int         m_t   [2];
   logic [7:0] m_cur [2];

   function automatic int cpb_of(input int d);
      return (d == 0) ? 4 : 256;
   endfunction

   always @(posedge clk) begin
      logic       rn;
      logic       dv;
      logic [7:0] b;
      bit         acc;
      bit         pop;
      for (int d = 0; d < 2; d++) begin
         rn = (d == 0) ? rst4_n : rst256_n;
         dv = (d == 0) ? if4.i_Tx_DV : if256.i_Tx_DV;
         b  = (d == 0) ? if4.i_Tx_Byte : if256.i_Tx_Byte;
         if (!rn) begin
            m_cnt[d]  = 0;
            m_busy[d] = 1'b0;
            m_t[d]    = 0;
         end else begin
            acc = (dv === 1'b1) && (m_cnt[d] < DEPTH);
            pop = !m_busy[d] && (m_cnt[d] > 0);
            if (m_busy[d]) begin
               if (m_t[d] == 10 * cpb_of(d)) m_busy[d] = 1'b0;
               else m_t[d]++;
            end
            if (pop) begin
               m_cur[d] = m_q[d][0];
               for (int j = 0; j < 15; j++) m_q[d][j] = m_q[d][j+1];
               m_cnt[d]--;
               m_busy[d] = 1'b1;
               m_t[d]    = 0;
            end
            if (acc) begin
               m_q[d][m_cnt[d]] = b;
               m_cnt[d]++;
            end
         end
      end
   end

   function automatic logic exp_serial(input int d);
      int k;
      if (!m_busy[d] || m_t[d] >= 10 * cpb_of(d)) return 1'b1;
      k = m_t[d] / cpb_of(d);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_cur[d][k-1];
   endfunction

   function automatic logic exp_active(input int d);
      return m_busy[d] && (m_t[d] < 10 * cpb_of(d));
   endfunction

   function automatic logic exp_done(input int d);
      return m_busy[d] && (m_t[d] == 10 * cpb_of(d));
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("serial4",   if4.o_Tx_Serial,   exp_serial(0));
         check("active4",   if4.o_Tx_Active,   exp_active(0));
         check("done4",     if4.o_Tx_Done,     exp_done(0));
         check("ready4",    if4.o_Tx_Ready,    m_cnt[0] < DEPTH);
         check("serial256", if256.o_Tx_Serial, exp_serial(1));
         check("active256", if256.o_Tx_Active, exp_active(1));
         check("done256",   if256.o_Tx_Done,   exp_done(1));
         check("ready256",  if256.o_Tx_Ready,  m_cnt[1] < DEPTH);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push4(input logic [7:0] b);
      if4.i_Tx_DV   = 1'b1;
      if4.i_Tx_Byte = b;
      tick(1);
      if4.i_Tx_DV   = 1'b0;
   endtask

   task automatic wait_idle4();
      int n = 0;
      while ((m_busy[0] || m_cnt[0] != 0) && n < 2000) begin
         tick(1);
         n++;
      end
      check("idle4_timeout", n < 2000, 1);
      tick(2);
   endtask

   // Bench-side receiver for the 4-clock instance: samples each bit mid-slot.
   task automatic rx4(output logic [7:0] b, output int fall, output bit ok);
      int   n = 0;
      logic st;
      logic sp;
      b    = '0;
      fall = cyc;
      ok   = 1'b0;
      while (if4.o_Tx_Serial !== 1'b0 && n < 400) begin
         tick(1);
         n++;
      end
      if (n >= 400) return;
      fall = cyc;
      tick(2);
      st = if4.o_Tx_Serial;
      for (int k = 0; k < 8; k++) begin
         tick(4);
         b[k] = if4.o_Tx_Serial;
      end
      tick(4);
      sp = if4.o_Tx_Serial;
      ok = (st == 1'b0) && (sp == 1'b1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [9:0] line;
      logic [7:0] rb;
      int         f0, f1, f2;
      bit         ok;
      int         bad, act_cnt, done_cnt, done_c, low_cnt;
      logic       rdy[6];
      logic       ser[6];
      int         runs[8];
      int         nruns, fall, last_e, donec;
      logic       prev, s;
      int         rate;

      if4.i_Tx_DV     = 1'b0;
      if4.i_Tx_Byte   = '0;
      if256.i_Tx_DV   = 1'b0;
      if256.i_Tx_Byte = '0;

      // Reset values and quiet line after release.
      tick(1);
      chk_en = 1'b1;
      tick(4);
      check("rst_serial", if4.o_Tx_Serial, 1);
      check("rst_ready",  if4.o_Tx_Ready,  1);
      check("rst_active", if4.o_Tx_Active, 0);
      check("rst_done",   if4.o_Tx_Done,   0);
      rst4_n   = 1'b1;
      rst256_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (if4.o_Tx_Serial !== 1'b1 || if4.o_Tx_Ready !== 1'b1 || if4.o_Tx_Active !== 1'b0)
            bad++;
      end
      check("idle_100", bad, 0);

      // 0xA5 frame shape: 0 | 1,0,1,0,0,1,0,1 | 1, four cycles each.
      line = 10'b1_1010_0101_0;
      push4(8'hA5);
      bad = 0; act_cnt = 0; done_cnt = 0; done_c = -1;
      for (int c = 1; c <= 46; c++) begin
         tick(1);
         if (c <= 40 && if4.o_Tx_Serial !== line[(c-1)/4]) bad++;
         if (if4.o_Tx_Active === 1'b1) act_cnt++;
         if (if4.o_Tx_Done === 1'b1) begin
            done_cnt++;
            done_c = c;
         end
      end
      check("a5_line",       bad,        0);
      check("a5_active_len", act_cnt,    40);
      check("a5_done_cnt",   done_cnt,   1);
      check("a5_done_delay", done_c - 1, 40);

      // Loopback of three back-to-back bytes.
      wait_idle4();
      fork
         begin
            push4(8'h00);
            push4(8'hFF);
            push4(8'h3C);
         end
         begin
            tick(1);
            rx4(rb, f0, ok);
            check("lb0_ok", ok, 1);
            check("lb0", rb, 8'h00);
            rx4(rb, f1, ok);
            check("lb1_ok", ok, 1);
            check("lb1", rb, 8'hFF);
            rx4(rb, f2, ok);
            check("lb2_ok", ok, 1);
            check("lb2", rb, 8'h3C);
         end
      join
      check("lb_gap01", f1 - f0, 42);
      check("lb_gap12", f2 - f1, 42);

      // Fill the FIFO: six consecutive pushes, fifth fills it, sixth dropped.
      wait_idle4();
      for (int i = 0; i < 6; i++) begin
         if4.i_Tx_DV   = 1'b1;
         if4.i_Tx_Byte = 8'(8'h10 + i);
         tick(1);
         rdy[i] = if4.o_Tx_Ready;
         ser[i] = if4.o_Tx_Serial;
      end
      if4.i_Tx_DV = 1'b0;
      check("fill_first_pop", ser[1], 0);
      check("fill_rdy4",      rdy[3], 1);
      check("fill_rdy5",      rdy[4], 0);
      check("fill_rdy6",      rdy[5], 0);
      done_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (if4.o_Tx_Done === 1'b1) done_cnt++;
      end
      check("fill_frames", done_cnt, 5);

      // Reset during data bit 3 of 0x81.
      wait_idle4();
      push4(8'h81);
      tick(18);
      rst4_n = 1'b0;
      tick(1);
      check("mrst_serial", if4.o_Tx_Serial, 1);
      check("mrst_active", if4.o_Tx_Active, 0);
      check("mrst_ready",  if4.o_Tx_Ready,  1);
      check("mrst_done",   if4.o_Tx_Done,   0);
      rst4_n = 1'b1;
      done_cnt = 0; low_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (if4.o_Tx_Done === 1'b1) done_cnt++;
         if (if4.o_Tx_Serial !== 1'b1) low_cnt++;
      end
      check("mrst_no_done",  done_cnt, 0);
      check("mrst_no_frame", low_cnt,  0);
      fork
         push4(8'h55);
         begin
            rx4(rb, f0, ok);
            check("mrst_55_ok", ok, 1);
            check("mrst_55",    rb, 8'h55);
         end
      join

      // 256 clocks per bit, byte 0x01: runs of 256 low, 256 high, 1792 low.
      if256.i_Tx_DV   = 1'b1;
      if256.i_Tx_Byte = 8'h01;
      tick(1);
      if256.i_Tx_DV   = 1'b0;
      prev = 1'b1; nruns = 0; fall = -1; last_e = 0; donec = -1;
      for (int i = 0; i < 8; i++) runs[i] = 0;
      for (int c = 1; c <= 2700; c++) begin
         tick(1);
         s = if256.o_Tx_Serial;
         if (s !== prev) begin
            if (fall < 0) fall = c;
            else if (nruns < 8) begin
               runs[nruns] = c - last_e;
               nruns++;
            end
            last_e = c;
            prev   = s;
         end
         if (if256.o_Tx_Done === 1'b1 && donec < 0) donec = c;
      end
      check("c256_fall",  fall,         1);
      check("c256_start", runs[0],      256);
      check("c256_bit0",  runs[1],      256);
      check("c256_zeros", runs[2],      1792);
      check("c256_done",  donec - fall, 2560);

      // Randomized pushes with varying rates and occasional resets.
      wait_idle4();
      for (int blk = 0; blk < 6; blk++) begin
         rate = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 20 : 60);
         for (int i = 0; i < 500; i++) begin
            if4.i_Tx_DV   = ($urandom_range(0, rate - 1) == 0);
            if4.i_Tx_Byte = 8'($urandom);
            rst4_n        = ($urandom_range(0, 699) != 0);
            tick(1);
         end
      end
      if4.i_Tx_DV = 1'b0;
      rst4_n      = 1'b1;
      wait_idle4();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
